// File: rtl/sound_countdown_timer_pkg.sv
// Shared types and helpers for the sound-gated countdown timer.
//   state_e : controller states
//   mode_e  : sensor gating modes (2'b11 is decoded as M_RELOAD by the timer)
//   bcd_t   : one BCD digit
//   bcd_clamp()   : saturate a digit to 9
//   bcd_is_zero() : digit equals 0
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    M_RELOAD = 2'b00,
    M_PAUSE  = 2'b01,
    M_FREE   = 2'b10
  } mode_e;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic bcd_is_zero(input bcd_t d);
    return (d == 4'd0);
  endfunction

endpackage

// File: rtl/sound_countdown_timer_snd_debounce.sv
// Sensor conditioning: 2-flop synchroniser followed by a level debouncer.
// Q takes a new level only after DEB_CYC consecutive synchronised samples
// that differ from the current Q; any sample equal to Q restarts the count.
// Ports:
//   CLK in  system clock
//   RST in  asynchronous active-high reset
//   D   in  raw asynchronous sensor level
//   Q   out debounced, synchronised level
module snd_debounce #(
  parameter int unsigned DEB_CYC = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  localparam int unsigned CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= D;
      sync2 <= sync1;
    end
  end

  // cnt holds the number of consecutive differing samples already seen,
  // so the DEB_CYC-th differing sample is the one that flips Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      Q   <= 1'b0;
    end else if (sync2 == Q) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYC - 1)) begin
      cnt <= '0;
      Q   <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sound_countdown_timer.sv
// Sound-gated multi-digit BCD countdown timer with internal tick prescaler.
// Ports:
//   CLK         in  system clock
//   RST         in  asynchronous active-high reset
//   EN          in  1 = armed, 0 = idle/preload
//   SOUNDSENSOR in  raw async sensor level
//   MODE        in  00 RELOAD, 01 PAUSE, 10 FREE, 11 RELOAD
//   LOAD_VAL    in  BCD preload (digits >9 clamped to 9)
//   ACK         in  restart from DONE
//   TSEG        out current BCD count
//   LED         out 1 while in DONE
//   DONE_P      out one-cycle pulse on entry into DONE
//   BUSY        out 1 while in RUN
module sound_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DEB_CYC  = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                SOUNDSENSOR,
  input  logic [1:0]          MODE,
  input  logic [4*DIGITS-1:0] LOAD_VAL,
  input  logic                ACK,
  output logic [4*DIGITS-1:0] TSEG,
  output logic                LED,
  output logic                DONE_P,
  output logic                BUSY
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);

  state_e        state, state_n;
  logic [W-1:0]  tseg_n;
  logic          done_p_n;
  logic [PW-1:0] presc, presc_n;
  logic          snd;
  logic          tick;

  logic [W-1:0]      load_clamped;
  logic [W-1:0]      dec_val;
  logic [DIGITS-1:0] load_dig_zero;
  logic [DIGITS-1:0] cur_dig_zero;
  logic [DIGITS-1:0] dec_dig_zero;
  logic [DIGITS-1:0] borrow;
  logic              load_zero;
  logic              dec_zero;

  snd_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_deb (
    .CLK(CLK),
    .RST(RST),
    .D  (SOUNDSENSOR),
    .Q  (snd)
  );

  // Per-digit clamp and ripple-borrow decrement; digit i borrows only when
  // every lower digit is 0.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign load_clamped[4*i +: 4] = bcd_clamp(LOAD_VAL[4*i +: 4]);
    assign load_dig_zero[i]       = bcd_is_zero(load_clamped[4*i +: 4]);
    assign cur_dig_zero[i]        = bcd_is_zero(TSEG[4*i +: 4]);
    if (i == 0) begin : g_b0
      assign borrow[i] = 1'b1;
    end else begin : g_bn
      assign borrow[i] = borrow[i-1] & cur_dig_zero[i-1];
    end
    assign dec_val[4*i +: 4] = !borrow[i]      ? TSEG[4*i +: 4] :
                               cur_dig_zero[i] ? 4'd9 :
                                                 TSEG[4*i +: 4] - 4'd1;
    assign dec_dig_zero[i] = bcd_is_zero(dec_val[4*i +: 4]);
  end

  assign load_zero = &load_dig_zero;
  // A zero count saturates at zero rather than wrapping to all nines.
  assign dec_zero  = (&cur_dig_zero) | (&dec_dig_zero);

  assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      TSEG   <= '0;
      DONE_P <= 1'b0;
      presc  <= '0;
    end else begin
      state  <= state_n;
      TSEG   <= tseg_n;
      DONE_P <= done_p_n;
      presc  <= presc_n;
    end
  end

  always_comb begin
    state_n  = state;
    tseg_n   = TSEG;
    done_p_n = 1'b0;
    presc_n  = '0;
    if (!EN) begin
      state_n = IDLE;
      tseg_n  = load_clamped;
    end else begin
      unique case (state)
        IDLE: begin
          tseg_n = load_clamped;
          if (load_zero) begin
            state_n  = DONE;
            done_p_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
        RUN: begin
          presc_n = tick ? '0 : presc + PW'(1);
          if (tick) begin
            if (MODE == M_FREE || snd) begin
              tseg_n = dec_zero ? '0 : dec_val;
              if (dec_zero) begin
                state_n  = DONE;
                done_p_n = 1'b1;
              end
            end else if (MODE != M_PAUSE) begin
              tseg_n = load_clamped;
            end
          end
        end
        DONE: begin
          tseg_n = '0;
          if (ACK) begin
            tseg_n = load_clamped;
            if (load_zero) begin
              done_p_n = 1'b1;
            end else begin
              state_n = RUN;
            end
          end
        end
        default: begin
          state_n = IDLE;
          tseg_n  = load_clamped;
        end
      endcase
    end
  end

  assign LED  = (state == DONE);
  assign BUSY = (state == RUN);

endmodule
